// File: rtl/prbs_pkg.sv
//------------------------------------------------------------------------------
// Module   : prbs_pkg
// Brief    : Shared defaults and FSM state type for the parallel PRBS checker.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package prbs_pkg;
  localparam int         POL_W_DEF    = 7;
  localparam int         DW_DEF       = 16;
  localparam logic [7:0] POL_MASK_DEF = 8'hC0;

  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } prbs_state_t;
endpackage

`default_nettype wire

// File: rtl/prbs_next_word.sv
//------------------------------------------------------------------------------
// Module   : prbs_next_word
// Brief    : Combinational next-word function F(seed), bit-identical to the
//            parallel PRBS word generator (bit 0 newest).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module prbs_next_word
  import prbs_pkg::*;
#(
  parameter int             POL_W    = POL_W_DEF,
  parameter logic [POL_W:0] POL_MASK = (POL_W+1)'(POL_MASK_DEF),
  parameter int             DW       = DW_DEF
) (
  input  logic [POL_W-1:0] i_seed,
  output logic [DW-1:0]    o_word
);

  logic [POL_W+DW-1:0] w_state;

  // Each new bit taps the POL_W+1 window starting at its own position, which
  // reaches back into already-computed newer bits and finally into the seed.
  always_comb begin
    w_state = {i_seed, {DW{1'b0}}};
    for (int i = DW - 1; i >= 0; i--) begin
      w_state[i] = ^(w_state[i +: POL_W+1] & POL_MASK);
    end
  end

  assign o_word = w_state[DW-1:0];

endmodule

`default_nettype wire

// File: rtl/prbs_checker.sv
//------------------------------------------------------------------------------
// Module   : prbs_checker
// Brief    : Self-synchronising parallel PRBS checker with lock tracking and
//            saturating error counters. PRBS_CHK_BITCNT_EN enables bit counts.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module prbs_checker
  import prbs_pkg::*;
#(
  parameter logic [7:0] POL_MASK   = POL_MASK_DEF,
  parameter int         POL_W      = POL_W_DEF,
  parameter int         DW         = DW_DEF,
  parameter int         LOCK_CNT   = 8,
  parameter int         UNLOCK_CNT = 4,
  parameter int         CNT_W      = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     data_valid,
  input  logic [DW-1:0]            data_in,
  input  logic                     clear_cnt,
  output logic                     locked,
  output logic                     err_word,
  output logic [$clog2(DW+1)-1:0]  err_bits,
  output logic [CNT_W-1:0]         word_err_cnt,
  output logic [CNT_W-1:0]         bit_err_cnt
);

  localparam int c_PW = $clog2(DW + 1);
  localparam int c_GW = $clog2(LOCK_CNT + 1);
  localparam int c_BW = $clog2(UNLOCK_CNT + 1);

  prbs_state_t      r_state, w_state_n;
  logic [POL_W-1:0] r_ref_seed, w_seed_n;
  logic             r_have_seed, w_have_n;
  logic [c_GW-1:0]  r_good_cnt, w_good_n, w_good_inc;
  logic [c_BW-1:0]  r_bad_cnt, w_bad_n, w_bad_inc;
  logic             r_err_word, w_err_n;
  logic [CNT_W-1:0] r_word_cnt;
  logic [DW-1:0]    w_exp, w_mism;
  logic             w_bad;

  prbs_next_word #(
    .POL_W    (POL_W),
    .POL_MASK (POL_MASK[POL_W:0]),
    .DW       (DW)
  ) u_next_word (
    .i_seed (r_ref_seed),
    .o_word (w_exp)
  );

  assign w_mism     = data_in ^ w_exp;
  assign w_bad      = |w_mism;
  assign w_good_inc = r_good_cnt + 1'b1;
  assign w_bad_inc  = r_bad_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= SEARCH;
      r_ref_seed  <= '0;
      r_have_seed <= 1'b0;
      r_good_cnt  <= '0;
      r_bad_cnt   <= '0;
      r_err_word  <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_ref_seed  <= w_seed_n;
      r_have_seed <= w_have_n;
      r_good_cnt  <= w_good_n;
      r_bad_cnt   <= w_bad_n;
      r_err_word  <= w_err_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_seed_n  = r_ref_seed;
    w_have_n  = r_have_seed;
    w_good_n  = r_good_cnt;
    w_bad_n   = r_bad_cnt;
    w_err_n   = 1'b0;
    if (data_valid) begin
      case (r_state)
        SEARCH: begin
          w_seed_n = data_in[POL_W-1:0];
          w_have_n = 1'b1;
          if (r_have_seed) begin
            if (w_bad) begin
              w_good_n = '0;
            end else if (w_good_inc == c_GW'(LOCK_CNT)) begin
              w_good_n  = '0;
              w_state_n = LOCKED;
            end else begin
              w_good_n = w_good_inc;
            end
          end
        end
        LOCKED: begin
          // Free-running reference so one channel error is counted once.
          w_seed_n = w_exp[POL_W-1:0];
          if (w_bad) begin
            w_err_n = 1'b1;
            if (w_bad_inc == c_BW'(UNLOCK_CNT)) begin
              w_state_n = SEARCH;
              w_bad_n   = '0;
              w_good_n  = '0;
              w_seed_n  = data_in[POL_W-1:0];
            end else begin
              w_bad_n = w_bad_inc;
            end
          end else begin
            w_bad_n = '0;
          end
        end
        default: begin
          w_state_n = SEARCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear_cnt) begin
      r_word_cnt <= '0;
    end else if (w_err_n && (r_word_cnt != {CNT_W{1'b1}})) begin
      r_word_cnt <= r_word_cnt + 1'b1;
    end
  end

`ifdef PRBS_CHK_BITCNT_EN
  logic [c_PW-1:0]  w_pop;
  logic [c_PW-1:0]  r_err_bits;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [CNT_W:0]   w_bit_sum;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < DW; i++) begin
      w_pop = w_pop + c_PW'(w_mism[i]);
    end
  end

  assign w_bit_sum = {1'b0, r_bit_cnt} + (CNT_W+1)'(w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_bits <= '0;
    end else if (data_valid) begin
      r_err_bits <= w_pop;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear_cnt) begin
      r_bit_cnt <= '0;
    end else if (w_err_n) begin
      r_bit_cnt <= w_bit_sum[CNT_W] ? {CNT_W{1'b1}} : w_bit_sum[CNT_W-1:0];
    end
  end

  assign err_bits    = r_err_bits;
  assign bit_err_cnt = r_bit_cnt;
`else
  assign err_bits    = '0;
  assign bit_err_cnt = '0;
`endif

  assign locked       = (r_state == LOCKED);
  assign err_word     = r_err_word;
  assign word_err_cnt = r_word_cnt;

endmodule

`default_nettype wire

// File: tb/tb_prbs_checker.sv
//------------------------------------------------------------------------------
// Module   : tb_prbs_checker
// Brief    : Directed self-checking bench for prbs_checker (CNT_W = 4).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_prbs_checker;

`ifdef PRBS_CHK_BITCNT_EN
  localparam int c_BC = 1;
`else
  localparam int c_BC = 0;
`endif

  logic        clk;
  logic        rst;
  logic        data_valid;
  logic [15:0] data_in;
  logic        clear_cnt;
  logic        locked;
  logic        err_word;
  logic [4:0]  err_bits;
  logic [3:0]  word_err_cnt;
  logic [3:0]  bit_err_cnt;

  int          n_total = 0;
  int          n_bad   = 0;
  logic [6:0]  r_tb_seed;

  prbs_checker #(
    .POL_MASK   (8'hC0),
    .POL_W      (7),
    .DW         (16),
    .LOCK_CNT   (8),
    .UNLOCK_CNT (4),
    .CNT_W      (4)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .data_valid   (data_valid),
    .data_in      (data_in),
    .clear_cnt    (clear_cnt),
    .locked       (locked),
    .err_word     (err_word),
    .err_bits     (err_bits),
    .word_err_cnt (word_err_cnt),
    .bit_err_cnt  (bit_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // x^7+x^6+1 written out directly: new bit = bit(+6) ^ bit(+7)
  function automatic logic [15:0] nxt(input logic [6:0] s);
    logic [22:0] v;
    v = {s, 16'h0000};
    for (int i = 15; i >= 0; i--) v[i] = v[i+6] ^ v[i+7];
    return v[15:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [15:0] d, input logic clr);
    data_valid = v;
    data_in    = d;
    clear_cnt  = clr;
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    clear_cnt  = 1'b0;
  endtask

  task automatic send(input logic [15:0] flip, input logic clr);
    logic [15:0] w;
    w = nxt(r_tb_seed);
    r_tb_seed = w[6:0];
    step(1'b1, w ^ flip, clr);
  endtask

  initial begin
    rst = 1'b1; data_valid = 1'b0; data_in = '0; clear_cnt = 1'b0; r_tb_seed = 7'h7F;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_locked", 32'(locked), 0);
    chk("rst_err_word", 32'(err_word), 0);
    chk("rst_err_bits", 32'(err_bits), 0);
    chk("rst_wcnt", 32'(word_err_cnt), 0);
    chk("rst_bcnt", 32'(bit_err_cnt), 0);
    rst = 1'b0;

    // acquisition: seed word, hand-computed first word, then model stream
    step(1'b1, 16'h007F, 1'b0);
    step(1'b1, 16'h020C, 1'b0);
    r_tb_seed = 7'h0C;
    repeat (6) send(16'h0, 1'b0);
    chk("acq_not_yet", 32'(locked), 0);
    send(16'h0, 1'b0);
    chk("acq_locked", 32'(locked), 1);
    chk("acq_wcnt", 32'(word_err_cnt), 0);
    chk("acq_bcnt", 32'(bit_err_cnt), 0);

    // single bit error
    repeat (3) send(16'h0, 1'b0);
    send(16'h0008, 1'b0);
    chk("e1_err_word", 32'(err_word), 1);
    chk("e1_err_bits", 32'(err_bits), 32'(c_BC));
    chk("e1_wcnt", 32'(word_err_cnt), 1);
    chk("e1_bcnt", 32'(bit_err_cnt), 32'(c_BC));
    send(16'h0, 1'b0);
    chk("e1_after_err_word", 32'(err_word), 0);
    chk("e1_after_err_bits", 32'(err_bits), 0);
    chk("e1_after_wcnt", 32'(word_err_cnt), 1);
    chk("e1_after_locked", 32'(locked), 1);
    send(16'h0, 1'b0);
    chk("e1_after2_err_word", 32'(err_word), 0);

    // unlock after four 2-bit errored words, then relock
    step(1'b0, 16'h0, 1'b1);
    chk("clr_wcnt", 32'(word_err_cnt), 0);
    chk("clr_bcnt", 32'(bit_err_cnt), 0);
    for (int i = 0; i < 3; i++) begin
      send(16'h0300, 1'b0);
      chk("ul_still_locked", 32'(locked), 1);
    end
    send(16'h0300, 1'b0);
    chk("ul_unlocked", 32'(locked), 0);
    chk("ul_err_word", 32'(err_word), 1);
    chk("ul_wcnt", 32'(word_err_cnt), 4);
    chk("ul_bcnt", 32'(bit_err_cnt), 32'(8 * c_BC));
    repeat (7) send(16'h0, 1'b0);
    chk("rl_not_yet", 32'(locked), 0);
    chk("rl_wcnt_held", 32'(word_err_cnt), 4);
    send(16'h0, 1'b0);
    chk("rl_locked", 32'(locked), 1);

    // valid gaps do not disturb the sequence
    step(1'b0, 16'h0, 1'b1);
    for (int c = 0; c < 80; c++) begin
      if ((c >= 30 && c < 50) || ($urandom_range(0, 1) == 0))
        step(1'b0, 16'($urandom), 1'b0);
      else
        send(16'h0, 1'b0);
      chk("gap_err_word", 32'(err_word), 0);
      chk("gap_locked", 32'(locked), 1);
    end
    chk("gap_wcnt", 32'(word_err_cnt), 0);

    // saturation with 4-bit counters
    step(1'b0, 16'h0, 1'b1);
    for (int k = 1; k <= 17; k++) begin
      send(16'h0100, 1'b0);
      send(16'h0, 1'b0);
      chk("sat_wcnt", 32'(word_err_cnt), (k > 15) ? 15 : k);
      chk("sat_bcnt", 32'(bit_err_cnt), 32'(c_BC * ((k > 15) ? 15 : k)));
    end
    chk("sat_locked", 32'(locked), 1);
    send(16'h0100, 1'b1);
    chk("clr_prio_wcnt", 32'(word_err_cnt), 0);
    chk("clr_prio_bcnt", 32'(bit_err_cnt), 0);
    chk("clr_prio_err_word", 32'(err_word), 1);
    chk("clr_prio_locked", 32'(locked), 1);

    // reset mid-lock overrides valid and clear
    send(16'h0, 1'b0);
    send(16'h0001, 1'b0);
    rst = 1'b1;
    send(16'h0001, 1'b1);
    chk("mrst_locked", 32'(locked), 0);
    chk("mrst_err_word", 32'(err_word), 0);
    chk("mrst_err_bits", 32'(err_bits), 0);
    chk("mrst_wcnt", 32'(word_err_cnt), 0);
    chk("mrst_bcnt", 32'(bit_err_cnt), 0);
    rst = 1'b0;
    repeat (8) send(16'h0, 1'b0);
    chk("reacq_not_yet", 32'(locked), 0);
    send(16'h0, 1'b0);
    chk("reacq_locked", 32'(locked), 1);
    chk("reacq_wcnt", 32'(word_err_cnt), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
